instruction_fetch: RTL

//  Fetch stage of the RISC-V core, directly upstream of instruction_memory.
//  - Owns the PC and drives the instruction memory byte address.
//  - Captures the returned 32-bit word into the IF/ID pipeline register.
//  - Handles hazard stalls, branch/jump redirects, boot warm-up, and halt on

---
 rtl/instruction_fetch.sv | 132 +++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, addresses instruction memory, and fills the IF/ID register.
// It also handles hazard stalls, branch/jump redirects, a one-cycle boot warm-up, and
// halting on an illegal PC or an all-zero instruction word.
module instruction_fetch #(
  parameter int unsigned         MEM_SIZE = 128,
  parameter int unsigned         XLEN     = 32,
  parameter logic [XLEN-1:0]     RESET_PC = '0,
  localparam int unsigned        AW       = $clog2(MEM_SIZE)
) (
  input  logic            clk,
  input  logic            rst,
  output logic [AW-1:0]   imem_addr,
  input  logic [31:0]     imem_data,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc4,
  output logic [31:0]     if_id_instr,
  output logic            halted,
  output logic [1:0]      halt_cause
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_ALIGN = 2'b01;
  localparam logic [1:0] CAUSE_RANGE = 2'b10;
  localparam logic [1:0] CAUSE_ZERO  = 2'b11;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // Highest PC whose four bytes all lie inside memory; anything above would wrap the
  // byte address while the memory assembles the word.
  localparam logic [XLEN-1:0] LAST_WORD = XLEN'(MEM_SIZE - 4);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic [XLEN-1:0] ipc4_q, ipc4_d;
  logic [1:0]      cause_q, cause_d;

  assign imem_addr   = pc_q[AW-1:0];
  assign if_id_valid = valid_q;
  assign if_id_pc    = ipc_q;
  assign if_id_pc4   = ipc4_q;
  assign if_id_instr = instr_q;
  assign halted      = (state_q == ST_HALT);
  assign halt_cause  = cause_q;

  // Next-state: redirect beats stall, stall beats fault checks, faults beat capture.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ipc4_d  = ipc4_q;
    cause_d = cause_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_i) begin
          // Target is not checked here; a bad target faults on its own fetch cycle.
          pc_d    = redirect_pc_i;
          valid_d = 1'b0;
        end else if (!stall_i) begin
          if (pc_q[1:0] != 2'b00) begin
            state_d = ST_HALT;
            cause_d = CAUSE_ALIGN;
            valid_d = 1'b0;
          end else if (pc_q > LAST_WORD) begin
            state_d = ST_HALT;
            cause_d = CAUSE_RANGE;
            valid_d = 1'b0;
          end else if (imem_data == 32'h0) begin
            state_d = ST_HALT;
            cause_d = CAUSE_ZERO;
            valid_d = 1'b0;
          end else begin
            instr_d = imem_data;
            ipc_d   = pc_q;
            ipc4_d  = pc_q + XLEN'(4);
            valid_d = 1'b1;
            pc_d    = pc_q + XLEN'(4);
          end
        end
      end
      ST_HALT: begin
        valid_d = 1'b0;
        if (redirect_i) begin
          pc_d    = redirect_pc_i;
          cause_d = CAUSE_NONE;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
        valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= NOP;
      ipc_q   <= '0;
      ipc4_q  <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc4_q  <= ipc4_d;
      cause_q <= cause_d;
    end
  end

endmodule
